// File: rtl/divfu.sv
// Iterative unsigned 8-bit divider FU at the head of the CDB/ROB result chains.
// Result is broadcast K+1 cycles after accept; it stalls in DONE while either upstream chain is claimed.
module divfu #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             input_transmit,
  input  logic [7:0]       operand,
  input  logic [1:0][7:0]  depvals,
  input  logic [7:0]       wbs,
  input  logic [7:0]       flags,
  input  logic [3:0]       robid,
  input  logic             cdb_transmit,
  output logic             cdb_transmit_out,
  output logic [3:0]       cdb_id,
  output logic [7:0]       cdb_val,
  input  logic             rob_transmit,
  output logic             rob_transmit_out,
  output logic [3:0]       robid_out,
  output logic [7:0]       flags_out,
  output logic [7:0]       wbs_out,
  output logic [7:0]       value_out,
  output logic             busy
);

  localparam int K = 8 / STEPS_PER_CYCLE;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0] state;
  logic [7:0] rem;
  logic [7:0] quo;
  logic [7:0] dvsr;
  logic [7:0] dvnd;
  logic [3:0] cnt;
  logic       op;
  logic [7:0] wbs_q;
  logic [7:0] flags_q;
  logic [3:0] robid_q;

  logic [7:0] rem_nx;
  logic [7:0] quo_nx;
  logic [7:0] ra;
  logic [7:0] qa;
  logic [8:0] t;
  logic [7:0] result;
  logic       drive;
  logic       unused_ok;

  assign unused_ok = ^operand[7:1];

  // One restoring step per iteration; the partial remainder only needs 9 bits after the shift.
  always_comb begin
    ra = rem;
    qa = quo;
    t  = 9'd0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      t  = {ra, qa[7]};
      qa = {qa[6:0], 1'b0};
      if (t >= {1'b0, dvsr}) begin
        t     = t - {1'b0, dvsr};
        qa[0] = 1'b1;
      end
      ra = t[7:0];
    end
    rem_nx = ra;
    quo_nx = qa;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rem     <= 8'd0;
      quo     <= 8'd0;
      dvsr    <= 8'd0;
      dvnd    <= 8'd0;
      cnt     <= 4'd0;
      op      <= 1'b0;
      wbs_q   <= 8'd0;
      flags_q <= 8'd0;
      robid_q <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (input_transmit) begin
            dvnd    <= depvals[0];
            quo     <= depvals[0];
            dvsr    <= depvals[1];
            rem     <= 8'd0;
            cnt     <= 4'(K);
            op      <= operand[0];
            wbs_q   <= wbs;
            flags_q <= flags;
            robid_q <= robid;
            state   <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          if (cnt == 4'd0) begin
            state <= S_DONE;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (drive) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign result = (dvsr == 8'd0) ? (op ? dvnd : 8'hFF) : (op ? rem : quo);

  // Both chains are claimed together or not at all.
  assign drive = (state == S_DONE) && !cdb_transmit && !rob_transmit;

  assign cdb_transmit_out = cdb_transmit | drive;
  assign rob_transmit_out = rob_transmit | drive;
  assign cdb_id    = drive ? wbs_q[3:0] : 4'd0;
  assign cdb_val   = drive ? result     : 8'd0;
  assign robid_out = drive ? robid_q    : 4'd0;
  assign flags_out = drive ? flags_q    : 8'd0;
  assign wbs_out   = drive ? wbs_q      : 8'd0;
  assign value_out = drive ? result     : 8'd0;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_divfu.sv
// Scoreboard bench for divfu: one S=1 and one S=4 instance, directed vectors.
module tb_divfu;

  typedef struct {
    int id;
    int val;
    int robid;
    int flags;
    int wbs;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic it1 = 1'b0, it4 = 1'b0;
  logic [7:0] operand = 8'd0;
  logic [1:0][7:0] dv = '0;
  logic [7:0] wbs = 8'd0, flags = 8'd0;
  logic [3:0] robid = 4'd0;
  logic cdb_t = 1'b0, rob_t = 1'b0;
  logic cdb_t4 = 1'b0, rob_t4 = 1'b0;

  logic c1_cout, c1_rout, busy1;
  logic [3:0] c1_id, c1_robid;
  logic [7:0] c1_val, c1_flags, c1_wbs, c1_vout;
  logic c4_cout, c4_rout, busy4;
  logic [3:0] c4_id, c4_robid;
  logic [7:0] c4_val, c4_flags, c4_wbs, c4_vout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;
  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  divfu #(.STEPS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst(rst), .input_transmit(it1), .operand(operand), .depvals(dv),
    .wbs(wbs), .flags(flags), .robid(robid),
    .cdb_transmit(cdb_t), .cdb_transmit_out(c1_cout), .cdb_id(c1_id), .cdb_val(c1_val),
    .rob_transmit(rob_t), .rob_transmit_out(c1_rout), .robid_out(c1_robid),
    .flags_out(c1_flags), .wbs_out(c1_wbs), .value_out(c1_vout), .busy(busy1)
  );

  divfu #(.STEPS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst(rst), .input_transmit(it4), .operand(operand), .depvals(dv),
    .wbs(wbs), .flags(flags), .robid(robid),
    .cdb_transmit(cdb_t4), .cdb_transmit_out(c4_cout), .cdb_id(c4_id), .cdb_val(c4_val),
    .rob_transmit(rob_t4), .rob_transmit_out(c4_rout), .robid_out(c4_robid),
    .flags_out(c4_flags), .wbs_out(c4_wbs), .value_out(c4_vout), .busy(busy4)
  );

  function automatic void chk(string nm, longint unsigned act, longint unsigned req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Monitor for the S=1 unit: pops an expectation whenever the unit drives its chains.
  always @(negedge clk) begin
    if (!rst) begin
      logic own_c, own_r;
      exp_t e;
      own_c = c1_cout & ~cdb_t;
      own_r = c1_rout & ~rob_t;
      if (own_c | own_r) begin
        chk("u1_drive_pair", own_c, own_r);
        if (q1.size() == 0) begin
          chk("u1_unexpected_bcast", 1, 0);
        end else begin
          e = q1.pop_front();
          chk("u1_cycle", cyc, e.cyc);
          chk("u1_cdb_id", c1_id, e.id);
          chk("u1_cdb_val", c1_val, e.val);
          chk("u1_value_out", c1_vout, e.val);
          chk("u1_robid_out", c1_robid, e.robid);
          chk("u1_flags_out", c1_flags, e.flags);
          chk("u1_wbs_out", c1_wbs, e.wbs);
        end
      end else begin
        chk("u1_idle_data", {c1_id, c1_val, c1_robid, c1_flags, c1_wbs, c1_vout}, 0);
        chk("u1_cdb_pass", c1_cout, cdb_t);
        chk("u1_rob_pass", c1_rout, rob_t);
      end
    end
  end

  // Monitor for the S=4 unit.
  always @(negedge clk) begin
    if (!rst) begin
      logic own_c, own_r;
      exp_t e;
      own_c = c4_cout & ~cdb_t4;
      own_r = c4_rout & ~rob_t4;
      if (own_c | own_r) begin
        chk("u4_drive_pair", own_c, own_r);
        if (q4.size() == 0) begin
          chk("u4_unexpected_bcast", 1, 0);
        end else begin
          e = q4.pop_front();
          chk("u4_cycle", cyc, e.cyc);
          chk("u4_cdb_id", c4_id, e.id);
          chk("u4_cdb_val", c4_val, e.val);
          chk("u4_value_out", c4_vout, e.val);
          chk("u4_robid_out", c4_robid, e.robid);
          chk("u4_flags_out", c4_flags, e.flags);
          chk("u4_wbs_out", c4_wbs, e.wbs);
        end
      end else begin
        chk("u4_idle_data", {c4_id, c4_val, c4_robid, c4_flags, c4_wbs, c4_vout}, 0);
        chk("u4_cdb_pass", c4_cout, cdb_t4);
        chk("u4_rob_pass", c4_rout, rob_t4);
      end
    end
  end

  // Called #1 after a posedge; presents an op for one edge and optionally queues its result.
  task automatic issue(input int u, input int dd, input int dr, input int op,
                       input int w, input int f, input int rid,
                       input int expv, input bit push, input int stall);
    exp_t e;
    dv[0] = 8'(dd);
    dv[1] = 8'(dr);
    operand = 8'(op);
    wbs = 8'(w);
    flags = 8'(f);
    robid = 4'(rid);
    if (u == 0) it1 = 1'b1; else it4 = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
    it1 = 1'b0;
    it4 = 1'b0;
    dv = '0;
    operand = 8'd0;
    wbs = 8'd0;
    flags = 8'd0;
    robid = 4'd0;
    if (push) begin
      e.id = w & 'hF;
      e.val = expv;
      e.robid = rid;
      e.flags = f;
      e.wbs = w;
      e.cyc = last_acc + ((u == 0) ? 8 : 2) + 1 + stall;
      if (u == 0) q1.push_back(e); else q4.push_back(e);
    end
  endtask

  task automatic wait_idle(input int u);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      if (u == 0 ? !busy1 : !busy4) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy1", busy1, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_data1", {c1_id, c1_val, c1_robid, c1_flags, c1_wbs, c1_vout}, 0);
    chk("rst_cdb_out", c1_cout, 0);
    chk("rst_rob_out", c1_rout, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 200/7 = 28 rem 4
    issue(0, 200, 7, 0, 'h3A, 'hC3, 5, 28, 1, 0);
    chk("busy_after_accept", busy1, 1);
    wait_idle(0);
    issue(0, 200, 7, 1, 'h3A, 'hC3, 5, 4, 1, 0);
    wait_idle(0);
    issue(1, 200, 7, 0, 'h3A, 'hC3, 5, 28, 1, 0);
    wait_idle(1);
    issue(1, 200, 7, 1, 'h3A, 'hC3, 5, 4, 1, 0);
    wait_idle(1);

    // divide by zero
    issue(0, 'h55, 0, 0, 'h21, 'h0F, 3, 'hFF, 1, 0);
    wait_idle(0);
    issue(0, 'h55, 0, 1, 'h21, 'h0F, 3, 'h55, 1, 0);
    wait_idle(0);

    // CDB upstream claimed for the first 3 DONE cycles: 100/9 = 11
    issue(0, 100, 9, 0, 'h47, 'h11, 7, 11, 1, 3);
    cdb_t = 1'b1;
    while (cyc < last_acc + 12) begin
      @(posedge clk);
      #1;
    end
    cdb_t = 1'b0;
    wait_idle(0);

    // same hold using ROB upstream only: 100 % 9 = 1
    issue(0, 100, 9, 1, 'h47, 'h11, 7, 1, 1, 3);
    rob_t = 1'b1;
    while (cyc < last_acc + 12) begin
      @(posedge clk);
      #1;
    end
    rob_t = 1'b0;
    wait_idle(0);

    // reset during the 4th DIVIDE cycle discards the op
    issue(0, 123, 5, 0, 'h66, 'h01, 4, 0, 0, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("busy_mid_divide", busy1, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("busy_after_rst", busy1, 0);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    issue(0, 255, 16, 0, 'hB2, 'h5A, 6, 15, 1, 0);
    wait_idle(0);
    issue(0, 255, 16, 1, 'hB2, 'h5A, 6, 15, 1, 0);
    wait_idle(0);

    // op issued while busy is ignored; next op right after busy falls is taken
    issue(0, 77, 6, 0, 'h5C, 'h99, 9, 12, 1, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    issue(0, 50, 3, 1, 'hEE, 'h12, 2, 0, 0, 0);
    wait_idle(0);
    issue(0, 50, 3, 1, 'hEE, 'h12, 2, 2, 1, 0);
    wait_idle(0);

    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("q1_drained", q1.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
